rr_mem_arbiter: RTL and testbench
=================================

RR_MEM_ARBITER -- requirements
Module: rr_mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesting cache channels (2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter LINE_W, default 256, cacheline width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ch_read  input  NUM_CH  per-channel line read request, held until ch_resp.
REQ-007 ch_write  input  NUM_CH  per-channel line write request, held until ch_resp.
REQ-008 ch_address  input  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 ch_wdata  input  NUM_CH*LINE_W  per-channel write line; channel i occupies bits [i*LINE_W +: LINE_W].
REQ-010 ch_resp  output  NUM_CH  one-hot completion pulse to the granted channel.
REQ-011 ch_rdata  output  LINE_W  read line, broadcast to all channels, valid with ch_resp.
REQ-012 mem_read / mem_write  output  1 each  request to cacheline adaptor.
REQ-013 mem_address  output  ADDR_W; mem_wdata  output  LINE_W; from latched request.
REQ-014 mem_resp  input  1; mem_rdata  input  LINE_W; completion from cacheline adaptor.
REQ-015 grant_id  output  $clog2(NUM_CH)  index of current/last granted channel.
REQ-016 busy  output  1  high in BUSY and DONE states.

Function
REQ-017 FSM SHALL have states IDLE, BUSY, DONE.
REQ-018 IDLE: channel i requesting iff ch_read[i]|ch_write[i]; with no requester, stay IDLE.
REQ-019 IDLE with >=1 requester: select winner by round-robin, search starting at ptr+1 mod NUM_CH; latch grant_id, address, wdata, op; go BUSY next edge.
REQ-020 Both ch_read[i] and ch_write[i] set: SHALL be treated as a write.
REQ-021 BUSY: mem_read or mem_write (latched op) asserted, exactly one; mem_address/mem_wdata from latch, stable until mem_resp.
REQ-022 BUSY with mem_resp=1: ch_resp[grant_id]=1 combinationally same cycle, ch_rdata=mem_rdata, mem_read/mem_write deasserted same cycle; ptr<=grant_id; go DONE.
REQ-023 DONE: one cycle, no arbitration, no ch_resp, mem_read=mem_write=0 (absorbs requester's deassert cycle); go IDLE.
REQ-024 Latency: request seen in IDLE cycle N -> mem request asserted cycle N+1; minimum back-to-back grant spacing 3 cycles after mem_resp cycle excluded.
REQ-025 Requests arriving/changing during BUSY/DONE SHALL NOT alter the latched transaction.
REQ-026 ch_rdata SHALL equal mem_rdata at all times (pass-through); only ch_resp qualifies it.
REQ-027 mem_resp outside BUSY SHALL be ignored.
REQ-028 Starvation bound: a held request SHALL be granted within NUM_CH grants.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, ptr=NUM_CH-1, grant_id=0, latched op/address/wdata=0.
REQ-030 During reset: mem_read=mem_write=0, ch_resp=0, busy=0, mem_address=0, mem_wdata=0.
REQ-031 Reset mid-BUSY SHALL abandon the transaction with no ch_resp; first grant after release goes to lowest-index requester.

Configuration
REQ-032 Macro ARB_FIXED_PRIO_EN: when defined, selection SHALL be fixed priority (lowest index wins) and ptr unused; when undefined, round-robin per REQ-019.

Verification
REQ-033 NUM_CH=2, ch_read=2'b11 held, mem_resp 4 cycles after each mem_read -> grants 0,1,0,1 (with ARB_FIXED_PRIO_EN: 0,0,0,0).
REQ-034 ch_write[1] alone, address 0x0000_1000, wdata pattern A5.. -> cycle+1 mem_write=1, mem_address=0x0000_1000; on mem_resp ch_resp=2'b10 same cycle.
REQ-035 ch_read[0] with mem_rdata=0xDEADBEEF.. on mem_resp -> ch_resp=2'b01, ch_rdata matches that cycle; DONE next cycle with no re-grant even if ch_read[0] still high.
REQ-036 reset_n low two cycles into BUSY -> mem_read drops same cycle asynchronously, no ch_resp; after release ch_read=2'b11 -> grant_id=0.
REQ-037 NUM_CH=4, all channels requesting continuously -> grant order 0,1,2,3,0; no channel waits more than 4 grants.
REQ-038 mem_resp pulsed in IDLE -> no ch_resp, state unchanged.

Source files
------------

// File: rtl/rr_mem_arbiter.sv
// rr_mem_arbiter
//   Arbitrates NUM_CH cache channels onto a single cacheline-adaptor port.
//   One transaction at a time: IDLE picks a winner and latches its request,
//   BUSY drives the adaptor until mem_resp, and DONE spends one cycle letting
//   the winner drop its request before the next arbitration.
//
//   Configuration macro: ARB_FIXED_PRIO_EN
//     undefined (default) : round-robin; the search starts one past the last
//                           granted channel
//     defined             : fixed priority, lowest index wins
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   ch_read        [NUM_CH]          per-channel read request (held until ch_resp)
//   ch_write       [NUM_CH]          per-channel write request (held until ch_resp)
//   ch_address     [NUM_CH*ADDR_W]   channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata       [NUM_CH*LINE_W]   channel i at [i*LINE_W +: LINE_W]
//   ch_resp        [NUM_CH]          one-hot completion to the granted channel
//   ch_rdata       [LINE_W]          read line, pass-through of mem_rdata
//   mem_read/mem_write               adaptor request (exactly one while BUSY)
//   mem_address, mem_wdata           latched request fields
//   mem_resp, mem_rdata              adaptor completion
//   grant_id       [clog2(NUM_CH)]   current / last granted channel
//   busy                             high in BUSY and DONE
module rr_mem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic                       mem_resp,
  input  logic [LINE_W-1:0]          mem_rdata,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CH_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [NUM_CH-1:0]   req_s;
  logic [IDX_W-1:0]    win_s;
  logic                win_valid_s;
  logic [IDX_W-1:0]    grant_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [LINE_W-1:0]   wdata_r;
  logic                op_write_r;
  logic                resp_s;

  assign req_s  = ch_read | ch_write;
  assign resp_s = (state_r == ST_BUSY) && mem_resp;

`ifdef ARB_FIXED_PRIO_EN

  // Winner select: fixed priority, scanning high to low so the lowest index overwrites last.
  always_comb begin
    win_s       = '0;
    win_valid_s = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      win_s       = req_s[i] ? IDX_W'(i) : win_s;
      win_valid_s = win_valid_s | req_s[i];
    end
  end

`else

  logic [IDX_W-1:0] ptr_r;
  logic [CH_W-1:0]  sum_s;
  logic [IDX_W-1:0] cand_s;
  logic             take_s;

  // Winner select: round-robin, candidates ptr+1 .. ptr+NUM_CH taken modulo NUM_CH.
  always_comb begin
    win_s       = '0;
    win_valid_s = 1'b0;
    sum_s       = '0;
    cand_s      = '0;
    take_s      = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      sum_s       = {1'b0, ptr_r} + CH_W'(i);
      // NUM_CH need not be a power of two, so wrap explicitly.
      sum_s       = (sum_s >= CH_W'(NUM_CH)) ? (sum_s - CH_W'(NUM_CH)) : sum_s;
      cand_s      = sum_s[IDX_W-1:0];
      take_s      = !win_valid_s && req_s[cand_s];
      win_s       = take_s ? cand_s : win_s;
      win_valid_s = win_valid_s | take_s;
    end
  end

  // Round-robin pointer: remembers the channel that last completed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= IDX_W'(NUM_CH - 1);
    end else if (resp_s) begin
      ptr_r <= grant_r;
    end
  end

`endif

  // Next-state logic for the IDLE -> BUSY -> DONE transaction sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_resp) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and transaction latch; the latch only loads on a grant in IDLE,
  // so requester activity during BUSY/DONE cannot disturb the transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      addr_r     <= '0;
      wdata_r    <= '0;
      op_write_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && win_valid_s) begin
        grant_r    <= win_s;
        addr_r     <= ch_address[win_s*ADDR_W +: ADDR_W];
        wdata_r    <= ch_wdata[win_s*LINE_W +: LINE_W];
        // A channel raising both read and write is serviced as a write.
        op_write_r <= ch_write[win_s];
      end
    end
  end

  // Completion pulse: combinational so the channel sees it in the mem_resp cycle.
  always_comb begin
    ch_resp = '0;
    if (resp_s) begin
      ch_resp = NUM_CH'(1) << grant_r;
    end else begin
      ch_resp = '0;
    end
  end

  // The adaptor request drops in the mem_resp cycle itself.
  assign mem_read    = (state_r == ST_BUSY) && !op_write_r && !mem_resp;
  assign mem_write   = (state_r == ST_BUSY) &&  op_write_r && !mem_resp;
  assign mem_address = addr_r;
  assign mem_wdata   = wdata_r;
  assign ch_rdata    = mem_rdata;
  assign grant_id    = grant_r;
  assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Self-checking bench for rr_mem_arbiter: a 2-channel instance for the directed
// cases and a 4-channel instance for the fairness sequence. Expected grants are
// queued when requests are driven and popped when the DUT completes.
module tb_rr_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // 2-channel instance
  logic [1:0]      ch_read2, ch_write2, ch_resp2;
  logic [2*AW-1:0] ch_address2;
  logic [2*LW-1:0] ch_wdata2;
  logic [LW-1:0]   ch_rdata2, mem_wdata2, mem_rdata2;
  logic            mem_read2, mem_write2, mem_resp2, busy2;
  logic [AW-1:0]   mem_address2;
  logic [0:0]      grant_id2;

  // 4-channel instance
  logic [3:0]      ch_read4, ch_write4, ch_resp4;
  logic [4*AW-1:0] ch_address4;
  logic [4*LW-1:0] ch_wdata4;
  logic [LW-1:0]   ch_rdata4, mem_wdata4, mem_rdata4;
  logic            mem_read4, mem_write4, mem_resp4, busy4;
  logic [AW-1:0]   mem_address4;
  logic [1:0]      grant_id4;

  rr_mem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .LINE_W(LW)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .ch_read(ch_read2), .ch_write(ch_write2),
    .ch_address(ch_address2), .ch_wdata(ch_wdata2),
    .ch_resp(ch_resp2), .ch_rdata(ch_rdata2),
    .mem_read(mem_read2), .mem_write(mem_write2),
    .mem_address(mem_address2), .mem_wdata(mem_wdata2),
    .mem_resp(mem_resp2), .mem_rdata(mem_rdata2),
    .grant_id(grant_id2), .busy(busy2)
  );

  rr_mem_arbiter #(.NUM_CH(4), .ADDR_W(AW), .LINE_W(LW)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .ch_read(ch_read4), .ch_write(ch_write4),
    .ch_address(ch_address4), .ch_wdata(ch_wdata4),
    .ch_resp(ch_resp4), .ch_rdata(ch_rdata4),
    .mem_read(mem_read4), .mem_write(mem_write4),
    .mem_address(mem_address4), .mem_wdata(mem_wdata4),
    .mem_resp(mem_resp4), .mem_rdata(mem_rdata4),
    .grant_id(grant_id4), .busy(busy4)
  );

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];
  int exp4_q[$];

  task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Serve one transaction on the 2-channel DUT: wait for the request, answer
  // after 'delay' cycles, then check the completion cycle and the DONE cycle.
  task automatic serve2(input logic exp_wr, input int delay, input logic [LW-1:0] rdata);
    int cnt;
    int g;
    logic [1:0]      er;
    logic [2*AW-1:0] sa;
    logic [2*LW-1:0] sw;
    cnt = 0;
    @(negedge clk);
    while (!(mem_read2 || mem_write2) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("req_latency", LW'(cnt), LW'(1));
    if (cnt >= 20) return;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", LW'(1'b1), LW'(1'b0));
      return;
    end
    g = exp_q.pop_front();
    check_eq("grant_id", LW'(grant_id2), LW'(g));
    check_eq("mem_write", LW'(mem_write2), LW'(exp_wr));
    check_eq("mem_read", LW'(mem_read2), LW'(!exp_wr));
    check_eq("mem_address", LW'(mem_address2), LW'(ch_address2[g*AW +: AW]));
    if (exp_wr) check_eq("mem_wdata", mem_wdata2, ch_wdata2[g*LW +: LW]);
    sa = ch_address2;
    sw = ch_wdata2;
    // Scramble the channel inputs while BUSY; the latched request must hold.
    @(posedge clk); #1;
    ch_address2 = ~sa;
    ch_wdata2   = ~sw;
    for (int k = 1; k < delay; k++) begin
      @(posedge clk); #1;
    end
    check_eq("addr_stable", LW'(mem_address2), LW'(sa[g*AW +: AW]));
    if (exp_wr) check_eq("wdata_stable", mem_wdata2, sw[g*LW +: LW]);
    check_eq("req_held", LW'(mem_read2 | mem_write2), LW'(1'b1));
    mem_resp2   = 1'b1;
    mem_rdata2  = rdata;
    ch_address2 = sa;
    ch_wdata2   = sw;
    @(negedge clk);
    er = 2'b01 << g;
    check_eq("ch_resp", LW'(ch_resp2), LW'(er));
    check_eq("ch_rdata", ch_rdata2, rdata);
    check_eq("req_drop", LW'(mem_read2 | mem_write2), LW'(1'b0));
    @(posedge clk); #1;
    mem_resp2 = 1'b0;
    @(negedge clk);
    check_eq("done_busy", LW'(busy2), LW'(1'b1));
    check_eq("done_noresp", LW'(ch_resp2), LW'(2'b00));
    check_eq("done_noreq", LW'(mem_read2 | mem_write2), LW'(1'b0));
  endtask

  initial begin
    int cnt;
    int g;
    int last[4];
    logic [LW-1:0] rd;
    logic [3:0] er4;

    reset_n     = 1'b0;
    ch_read2    = 2'b00;
    ch_write2   = 2'b00;
    ch_address2 = {32'h0000_1000, 32'h0000_2000};
    ch_wdata2   = {{32{8'hA5}}, {32{8'h3C}}};
    mem_resp2   = 1'b0;
    mem_rdata2  = '0;
    ch_read4    = 4'h0;
    ch_write4   = 4'h0;
    ch_address4 = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    ch_wdata4   = '0;
    mem_resp4   = 1'b0;
    mem_rdata4  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_read", LW'(mem_read2), LW'(1'b0));
    check_eq("rst_mem_write", LW'(mem_write2), LW'(1'b0));
    check_eq("rst_busy", LW'(busy2), LW'(1'b0));
    check_eq("rst_ch_resp", LW'(ch_resp2), LW'(2'b00));
    check_eq("rst_grant", LW'(grant_id2), LW'(1'b0));
    check_eq("rst_mem_address", LW'(mem_address2), LW'(32'h0));
    check_eq("rst_mem_wdata", mem_wdata2, LW'(1'b0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Both channels reading continuously: alternating grants
    @(posedge clk); #1;
    ch_read2 = 2'b11;
`ifdef ARB_FIXED_PRIO_EN
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
`else
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
`endif
    for (int t = 0; t < 4; t++) begin
      rd = {8{$urandom()}};
      serve2(1'b0, 4, rd);
    end
    ch_read2 = 2'b00;

    // Lone write from channel 1
    @(posedge clk); #1;
    ch_write2 = 2'b10;
    exp_q.push_back(1);
    serve2(1'b1, 3, {8{32'h1234_5678}});
    ch_write2 = 2'b00;

    // Lone read from channel 0, held through DONE
    @(posedge clk); #1;
    ch_read2 = 2'b01;
    exp_q.push_back(0);
    serve2(1'b0, 2, {8{32'hDEAD_BEEF}});
    ch_read2 = 2'b00;
    @(negedge clk);
    check_eq("no_regrant", LW'(busy2), LW'(1'b0));

    // Read and write together on one channel is serviced as a write
    @(posedge clk); #1;
    ch_read2  = 2'b01;
    ch_write2 = 2'b01;
    exp_q.push_back(0);
    serve2(1'b1, 1, {8{32'h0BAD_F00D}});
    ch_read2  = 2'b00;
    ch_write2 = 2'b00;

    // mem_resp while IDLE is ignored; ch_rdata follows mem_rdata regardless
    @(posedge clk); #1;
    mem_resp2  = 1'b1;
    mem_rdata2 = {8{32'hCAFE_0001}};
    @(negedge clk);
    check_eq("idle_resp_noresp", LW'(ch_resp2), LW'(2'b00));
    check_eq("idle_resp_busy", LW'(busy2), LW'(1'b0));
    check_eq("rdata_passthru", ch_rdata2, {8{32'hCAFE_0001}});
    @(posedge clk); #1;
    mem_resp2 = 1'b0;
    @(negedge clk);
    check_eq("idle_resp_after", LW'(busy2), LW'(1'b0));

    // Reset in the second BUSY cycle abandons the transaction
    @(posedge clk); #1;
    ch_read2 = 2'b10;
    cnt = 0;
    @(negedge clk);
    while (!mem_read2 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("pre_rst_req", LW'(mem_read2), LW'(1'b1));
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_mem_read", LW'(mem_read2), LW'(1'b0));
    check_eq("async_rst_ch_resp", LW'(ch_resp2), LW'(2'b00));
    check_eq("async_rst_busy", LW'(busy2), LW'(1'b0));
    check_eq("async_rst_grant", LW'(grant_id2), LW'(1'b0));
    ch_read2 = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.push_back(0);
    serve2(1'b0, 2, {8{32'h5555_AAAA}});
    ch_read2 = 2'b00;

    // Four channels, all requesting: fairness sequence
    @(posedge clk); #1;
    ch_read4 = 4'hF;
`ifdef ARB_FIXED_PRIO_EN
    for (int t = 0; t < 5; t++) exp4_q.push_back(0);
`else
    exp4_q.push_back(0); exp4_q.push_back(1); exp4_q.push_back(2);
    exp4_q.push_back(3); exp4_q.push_back(0);
`endif
    for (int c = 0; c < 4; c++) last[c] = -1;
    for (int k = 0; k < 5; k++) begin
      cnt = 0;
      @(negedge clk);
      while (!mem_read4 && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      check_eq("req4_seen", LW'(mem_read4), LW'(1'b1));
      if (cnt >= 20) break;
      @(posedge clk); #1;
      mem_resp4 = 1'b1;
      @(negedge clk);
      g = exp4_q.pop_front();
      er4 = 4'b0001 << g;
      check_eq("grant4", LW'(grant_id4), LW'(g));
      check_eq("ch_resp4", LW'(ch_resp4), LW'(er4));
      check_eq("starve4", LW'((k - last[grant_id4]) <= 4), LW'(1'b1));
      last[grant_id4] = k;
      @(posedge clk); #1;
      mem_resp4 = 1'b0;
    end
    ch_read4 = 4'h0;

    check_eq("sb_drained", LW'(exp_q.size() + exp4_q.size()), LW'(0));
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
